// File: rtl/apb_ram_slave.sv
// APB slave around a DEPTH x DATA_WIDTH word-addressed RAM; one wait state per transfer.
// Define APB_RAM_SLVERR_EN to flag out-of-range accesses with pslverr; otherwise addresses wrap modulo DEPTH.
module apb_ram_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 32
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  start;

    always_comb begin
        idx = IDX_W'(paddr);
`ifdef APB_RAM_SLVERR_EN
        in_range = (paddr < ADDR_WIDTH'(DEPTH));
`else
        in_range = 1'b1;
`endif
        // The operation fires on the edge that moves the FSM into ACCESS.
        start = psel && penable && ((state == IDLE) || (state == SETUP));
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;

            case (state)
                IDLE:   if (psel) state <= penable ? ACCESS : SETUP;
                SETUP:  if (!psel) state <= IDLE;
                        else if (penable) state <= ACCESS;
                ACCESS: state <= DONE;
                DONE:   state <= (psel && !penable) ? SETUP : IDLE;
                default: state <= IDLE;
            endcase

            if (start) begin
                pready  <= 1'b1;
                pslverr <= !in_range;
                if (pwrite) begin
                    if (in_range) mem[idx] <= pwdata;
                end else begin
                    prdata <= in_range ? mem[idx] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_ram_slave.sv
// Scoreboard bench for apb_ram_slave: driver pushes expected responses, a negedge monitor checks them.
// Honours APB_RAM_SLVERR_EN the same way as the design build.
module tb_apb_ram_slave;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 32;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    always #5 pclk = ~pclk;

    apb_ram_slave #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          slverr;
        logic [AW-1:0] addr;
        bit            wr;
    } exp_t;

    exp_t          exp_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] ref_mem[DEPTH];
    logic [DW-1:0] ref_prdata;
    logic          prev_pready = 1'b0;

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        foreach (ref_mem[i]) ref_mem[i] = '0;
        ref_prdata = '0;
    endfunction

    // Reference: RAM as a plain array, addresses wrap or fault depending on build.
    function automatic void model_issue(bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
        exp_t        e;
        bit          inr;
        int unsigned slot;
`ifdef APB_RAM_SLVERR_EN
        inr = (a < DEPTH);
`else
        inr = 1'b1;
`endif
        slot = a % DEPTH;
        if (wr && inr) ref_mem[slot] = d;
        if (!wr) ref_prdata = inr ? ref_mem[slot] : '0;
        e.rdata  = ref_prdata;
        e.slverr = !inr;
        e.addr   = a;
        e.wr     = wr;
        exp_q.push_back(e);
    endfunction

    always @(negedge pclk) begin
        exp_t e;
        if (presetn === 1'b1) begin
            if (pready === 1'b1) begin
                check("pready_single_cycle", {31'b0, prev_pready}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pready: actual=1 required=0 (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check(e.wr ? "wr_prdata_hold" : "rd_prdata", prdata, e.rdata);
                    check("pslverr", {31'b0, pslverr}, {31'b0, e.slverr});
                end
            end else begin
                check("idle_pslverr", {31'b0, pslverr}, 32'd0);
            end
        end
        prev_pready = pready;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    // Starts just after a clock edge; leaves the bus idle unless the next call follows at once.
    task automatic xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        model_issue(wr, a, d);
        @(posedge pclk);
        #1;
        check("ready_latency", {31'b0, pready}, 32'd1);
        for (int i = 0; i < 4 && pready !== 1'b1; i++) begin
            @(posedge pclk);
            #1;
        end
        @(posedge pclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        presetn = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        presetn = 1'b1;
        check("reset_pready", {31'b0, pready}, 32'd0);
        check("reset_pslverr", {31'b0, pslverr}, 32'd0);
        check("reset_prdata", prdata, 32'd0);
        idle(1);

        xfer(1'b0, 32'd5, '0);
        idle(1);

        xfer(1'b1, 32'd3, 32'hDEADBEEF);
        xfer(1'b0, 32'd3, '0);
        idle(2);

        for (int i = 0; i < 20; i++) begin
            xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom());
        end
        idle(2);

        xfer(1'b1, 32'd40, 32'h12345678);
        xfer(1'b0, 32'd8, '0);
        xfer(1'b0, 32'd40, '0);
        idle(2);

        // penable without psel must be ignored entirely.
        psel    = 1'b0;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'd3;
        pwdata  = 32'hFFFF0000;
        idle(5);
        penable = 1'b0;
        xfer(1'b0, 32'd3, '0);
        idle(1);

        xfer(1'b1, 32'd7, 32'h11111111);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'd7;
        pwdata  = 32'hA5A5A5A5;
        @(posedge pclk);
        #1;
        penable = 1'b1;
        presetn = 1'b0;
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        model_reset();
        check("midreset_pready", {31'b0, pready}, 32'd0);
        check("midreset_prdata", prdata, 32'd0);
        idle(3);
        xfer(1'b0, 32'd7, '0);
        idle(2);

        for (int i = 0; i < 30; i++) begin
            xfer(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom());
            idle($urandom_range(0, 2));
        end
        idle(3);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb_ram_slave.md
Name: apb_ram_slave

Overview:
- APB (AMBA 3 style) slave wrapping a small word-addressed RAM: DEPTH words of DATA_WIDTH bits.
- Sits on the peripheral bus behind an APB master/bridge.
- Completes each transfer with exactly one wait state.
- Flags out-of-range accesses with pslverr.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata and of each RAM word.
- DEPTH, 32, number of RAM words; valid word addresses are 0..DEPTH-1.

Ports:
- pclk  input  1  APB clock; all logic on its rising edge.
- presetn  input  1  synchronous, active-low reset.
- psel  input  1  slave select.
- penable  input  1  access-phase strobe.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_WIDTH  word address, not byte address.
- pwdata  input  DATA_WIDTH  write data.
- prdata  output  DATA_WIDTH  read data, registered.
- pready  output  1  transfer complete, registered.
- pslverr  output  1  error response, registered; valid only while pready=1.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. presetn=0 sampled at a pclk edge forces:
  - pready=0, pslverr=0, prdata=0
  - FSM to IDLE
  - all DEPTH RAM words to 0
- Reset mid-transfer aborts the transfer; no RAM write occurs that cycle.
- FSM states and transitions (registered):
  - IDLE: go to SETUP when psel=1 and penable=0. If psel=1 and penable=1, go directly to ACCESS (tolerant entry).
  - SETUP: go to ACCESS when psel=1 and penable=1. Go to IDLE if psel=0.
  - ACCESS: on the first ACCESS edge the slave performs the operation and registers pready=1. On the next edge the FSM goes to DONE.
  - DONE: pready driven 0. Go to SETUP if psel=1 and penable=0 (back-to-back), otherwise IDLE.
- Timing: pready is high for exactly one cycle per transfer, the cycle after penable is first sampled high (one wait state). The master completes on that cycle.
- Write (pwrite=1, in range):
  - mem[paddr] <= pwdata on the same edge that raises pready.
  - prdata holds its previous value.
- Read (pwrite=0, in range):
  - prdata <= mem[paddr] on the same edge that raises pready.
  - Value is stable while pready=1 and holds until the next read.
- Address check: in range means paddr < DEPTH, compared on the full ADDR_WIDTH.
- Control and address stability: paddr, pwrite and pwdata are sampled on the edge that raises pready. They must be stable from SETUP through ACCESS per APB.
- Ignored inputs: penable=1 with psel=0 is ignored; no state change, no RAM access.
- Idle outputs: pready=0 and pslverr=0 whenever not completing a transfer.
- Write-then-read: a read of an address written in the previous transfer returns the new data.
- Unwritten words read 0 after reset.

Optional Feature:
- Macro APB_RAM_SLVERR_EN.
- Defined:
  - Out-of-range access (paddr >= DEPTH) completes normally with pready=1 and pslverr=1 for that cycle.
  - Out-of-range writes are dropped; RAM is unchanged.
  - Out-of-range reads return prdata=0.
- Undefined:
  - pslverr is tied 0.
  - The address is taken modulo DEPTH (low log2(DEPTH) bits), so every access hits a RAM word.

Test Plan:
- Reset: hold presetn=0 for 2 cycles, then release → pready=0, pslverr=0, prdata=0. Reading addr 5 afterwards returns 0.
- Single write then read: write paddr=3, pwdata=0xDEADBEEF; then read paddr=3 → pready high exactly one cycle after penable rises, prdata=0xDEADBEEF, pslverr=0.
- Back-to-back: 20 random transfers to addr 0..31 with no idle cycles, checked against a reference memory model → every read matches last write (0 if never written), each pready pulse lasts one cycle.
- Out-of-range with APB_RAM_SLVERR_EN: write paddr=40, pwdata=0x12345678 → pslverr=1 with pready. Read addr 8 → unchanged. Read paddr=40 → prdata=0, pslverr=1. Without the macro: the write lands at addr 8 and pslverr=0.
- Reset mid-transfer: assert presetn=0 during ACCESS of write addr 7 = 0xA5A5A5A5 → no pready pulse, FSM IDLE. Later read addr 7 → 0.
- Protocol robustness: penable=1 with psel=0 for several cycles → pready stays 0, RAM unchanged.
